// File: rtl/shift_reg_pkg.sv
// rtl/shift_reg_pkg.sv - shared mode/state encodings for shift_reg_n.
// Imported by shift_reg_n; optional X-bit extension is selected by SHIFT_REG_N_XBIT_EN.
package shift_reg_pkg;

  typedef enum logic [1:0] {
    SM_SRL = 2'b00,
    SM_SRA = 2'b01,
    SM_SLL = 2'b10,
    SM_ROR = 2'b11
  } shift_mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } shift_state_e;

endpackage

// File: rtl/shift_reg_n_if.sv
// rtl/shift_reg_n_if.sv - command/data bundle between controller and shift_reg_n.
// X_In/X_Load/X exist only when SHIFT_REG_N_XBIT_EN is defined.
interface shift_reg_n_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
);
  logic             Load;
  logic [WIDTH-1:0] D;
  logic             Start;
  logic [1:0]       Mode;
  logic [CNT_W-1:0] Count;
  logic             Shift_In;
  logic             Busy;
  logic             Done;
  logic             Shift_Out;
  logic [WIDTH-1:0] Data_Out;
`ifdef SHIFT_REG_N_XBIT_EN
  logic             X_In;
  logic             X_Load;
  logic             X;

  modport master (
    output Load, D, Start, Mode, Count, Shift_In, X_In, X_Load,
    input  Busy, Done, Shift_Out, Data_Out, X
  );
  modport slave (
    input  Load, D, Start, Mode, Count, Shift_In, X_In, X_Load,
    output Busy, Done, Shift_Out, Data_Out, X
  );
`else
  modport master (
    output Load, D, Start, Mode, Count, Shift_In,
    input  Busy, Done, Shift_Out, Data_Out
  );
  modport slave (
    input  Load, D, Start, Mode, Count, Shift_In,
    output Busy, Done, Shift_Out, Data_Out
  );
`endif
endinterface

// File: rtl/shift_reg_n_step_counter.sv
// rtl/shift_reg_n_step_counter.sv - loadable down-counter of remaining shift steps.
// o_last flags the final step so the FSM can finish in the same cycle.
module shift_step_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_last
);
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_last = (r_count == CNT_W'(1));
endmodule

// File: rtl/shift_reg_n.sv
// rtl/shift_reg_n.sv - multi-mode shift register with counted start/busy/done command.
// Define SHIFT_REG_N_XBIT_EN to add the X extension bit used as SRA fill.
module shift_reg_n
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic         Clk,
  input  logic         Reset_n,
  shift_reg_n_if.slave bus
);
  shift_state_e     r_state;
  shift_mode_e      r_mode;
  logic [WIDTH-1:0] r_data;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] w_count_clamped;
  logic [WIDTH-1:0] w_step;
  logic             w_msb_fill;
  logic             w_hold_off;
  logic             w_accept_start;
  logic             w_last;

`ifdef SHIFT_REG_N_XBIT_EN
  logic r_x;
  assign w_msb_fill = r_x;
  assign w_hold_off = bus.Load | bus.X_Load;
  assign bus.X      = r_x;
`else
  assign w_msb_fill = r_data[WIDTH-1];
  assign w_hold_off = bus.Load;
`endif

  assign w_count_clamped = (bus.Count > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : bus.Count;
  assign w_accept_start  = (r_state == ST_IDLE) && bus.Start && !w_hold_off;

  shift_step_counter #(.CNT_W(CNT_W)) u_step_counter (
    .clk        (Clk),
    .rst_n      (Reset_n),
    .i_load     (w_accept_start),
    .i_load_val (w_count_clamped),
    .i_dec      (r_state == ST_SHIFT),
    .o_last     (w_last)
  );

  always_comb begin
    w_step = r_data;
    case (r_mode)
      SM_SRL:  w_step = {bus.Shift_In, r_data[WIDTH-1:1]};
      SM_SRA:  w_step = {w_msb_fill, r_data[WIDTH-1:1]};
      SM_SLL:  w_step = {r_data[WIDTH-2:0], bus.Shift_In};
      SM_ROR:  w_step = {r_data[0], r_data[WIDTH-1:1]};
      default: w_step = r_data;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= ST_IDLE;
      r_mode  <= SM_SRL;
      r_data  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef SHIFT_REG_N_XBIT_EN
      r_x     <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
`ifdef SHIFT_REG_N_XBIT_EN
          if (bus.X_Load) r_x <= bus.X_In;
`endif
          if (bus.Load) begin
            r_data <= bus.D;
          end else if (w_accept_start) begin
            r_mode <= shift_mode_e'(bus.Mode);
            // A zero-length command completes without ever becoming busy.
            if (w_count_clamped == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state <= ST_SHIFT;
              r_busy  <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          r_data <= w_step;
          if (w_last) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.Busy      = r_busy;
  assign bus.Done      = r_done;
  assign bus.Data_Out  = r_data;
  assign bus.Shift_Out = (r_mode == SM_SLL) ? r_data[WIDTH-1] : r_data[0];
endmodule

// File: tb/tb_shift_reg_n.sv
// tb/tb_shift_reg_n.sv - randomized self-checking bench for shift_reg_n.
module tb_shift_reg_n;
  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);
`ifdef SHIFT_REG_N_XBIT_EN
  localparam bit XBIT = 1'b1;
`else
  localparam bit XBIT = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  logic model_x;

  shift_reg_n_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  shift_reg_n #(.WIDTH(W), .CNT_W(CW)) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_step(input logic [W-1:0] v, input int mode,
                                            input logic sin, input logic xb);
    logic [W-1:0] r;
    case (mode)
      0: r = (v >> 1) | (W'(sin) << (W - 1));
      1: r = XBIT ? ((v >> 1) | (W'(xb) << (W - 1))) : W'($signed(v) >>> 1);
      2: r = (v << 1) | W'(sin);
      default: r = (v >> 1) | (v << (W - 1));
    endcase
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [W-1:0] d);
    bus.Load = 1'b1;
    bus.D    = d;
    step();
    bus.Load = 1'b0;
  endtask

  task automatic do_start(input int mode, input int cnt);
    bus.Start = 1'b1;
    bus.Mode  = mode[1:0];
    bus.Count = CW'(cnt);
    step();
    bus.Start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    step();
    do_load(8'hFF);
    do_start(0, 5);
    step();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.Data_Out !== 8'h00 || bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: data=%h busy=%b done=%b required data=00 busy=0 done=0",
               bus.Data_Out, bus.Busy, bus.Done);
    end
    model_x = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.Done !== 1'b0 || bus.Busy !== 1'b0 || bus.Data_Out !== 8'h00) begin
        errors++;
        $display("FAIL reset_after cyc %0d: data=%h busy=%b done=%b required 00/0/0",
                 i, bus.Data_Out, bus.Busy, bus.Done);
      end
    end
  endtask

  task automatic test_load();
    do_load(8'hB4);
    checks++;
    if (bus.Data_Out !== 8'hB4 || bus.Done !== 1'b0 || bus.Busy !== 1'b0) begin
      errors++;
      $display("FAIL load: data=%h done=%b busy=%b required B4/0/0",
               bus.Data_Out, bus.Done, bus.Busy);
    end
  endtask

  task automatic test_sra();
    logic [W-1:0] exp;
    exp = 8'h94;
    do_load(exp);
    do_start(1, 3);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.Busy !== 1'b1 || bus.Done !== 1'b0) begin
        errors++;
        $display("FAIL sra_busy cyc %0d: busy=%b done=%b required 1/0", i, bus.Busy, bus.Done);
      end
      step();
      exp = ref_step(exp, 1, 1'b0, model_x);
      checks++;
      if (bus.Data_Out !== exp) begin
        errors++;
        $display("FAIL sra_data step %0d: got %h required %h", i, bus.Data_Out, exp);
      end
    end
    checks++;
    if (bus.Done !== 1'b1 || bus.Busy !== 1'b0) begin
      errors++;
      $display("FAIL sra_done: done=%b busy=%b required 1/0", bus.Done, bus.Busy);
    end
    step();
    checks++;
    if (bus.Done !== 1'b0) begin
      errors++;
      $display("FAIL sra_done_once: done=%b required 0", bus.Done);
    end
  endtask

  task automatic test_sll();
    logic [7:0] exp_d [2];
    exp_d[0] = 8'h03;
    exp_d[1] = 8'h07;
    do_load(8'h81);
    bus.Shift_In = 1'b1;
    do_start(2, 2);
    checks++;
    if (bus.Shift_Out !== 1'b1) begin
      errors++;
      $display("FAIL sll_so0: got %b required 1", bus.Shift_Out);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (bus.Data_Out !== exp_d[i] || bus.Shift_Out !== 1'b0) begin
        errors++;
        $display("FAIL sll step %0d: data=%h so=%b required %h/0",
                 i, bus.Data_Out, bus.Shift_Out, exp_d[i]);
      end
    end
    checks++;
    if (bus.Done !== 1'b1) begin
      errors++;
      $display("FAIL sll_done: got %b required 1", bus.Done);
    end
    bus.Shift_In = 1'b0;
    step();
  endtask

  task automatic test_ror_clamp();
    int busy_cycles;
    bit seen_done;
    do_load(8'h01);
    do_start(3, 9);
    busy_cycles = 0;
    seen_done   = 1'b0;
    for (int i = 0; i < 20 && !seen_done; i++) begin
      if (bus.Busy === 1'b1) busy_cycles++;
      if (bus.Done === 1'b1) seen_done = 1'b1;
      else step();
    end
    checks++;
    if (!seen_done || busy_cycles != 8 || bus.Data_Out !== 8'h01) begin
      errors++;
      $display("FAIL ror_clamp: done_seen=%0d busy_cycles=%0d data=%h required 1/8/01",
               seen_done, busy_cycles, bus.Data_Out);
    end
    step();
  endtask

  task automatic test_collisions();
    logic [W-1:0] exp;
    bus.Load  = 1'b1;
    bus.D     = 8'h5A;
    bus.Start = 1'b1;
    bus.Mode  = 2'd0;
    bus.Count = CW'(3);
    step();
    bus.Load  = 1'b0;
    bus.Start = 1'b0;
    checks++;
    if (bus.Data_Out !== 8'h5A || bus.Busy !== 1'b0) begin
      errors++;
      $display("FAIL coll_load_start: data=%h busy=%b required 5A/0", bus.Data_Out, bus.Busy);
    end
    step();
    checks++;
    if (bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
      errors++;
      $display("FAIL coll_start_dropped: busy=%b done=%b required 0/0", bus.Busy, bus.Done);
    end

    exp = 8'h5A;
    bus.Shift_In = 1'b0;
    do_start(0, 4);
    for (int i = 0; i < 4; i++) begin
      bus.Load  = 1'b1;
      bus.D     = 8'hFF;
      bus.Start = 1'b1;
      bus.Mode  = 2'd2;
      bus.Count = CW'(1);
      step();
      exp = ref_step(exp, 0, 1'b0, model_x);
      checks++;
      if (bus.Data_Out !== exp) begin
        errors++;
        $display("FAIL coll_busy_ignore step %0d: got %h required %h", i, bus.Data_Out, exp);
      end
    end
    bus.Load  = 1'b0;
    bus.Start = 1'b0;
    checks++;
    if (bus.Done !== 1'b1 || bus.Busy !== 1'b0) begin
      errors++;
      $display("FAIL coll_busy_done: done=%b busy=%b required 1/0", bus.Done, bus.Busy);
    end
    step();

    do_start(1, 0);
    checks++;
    if (bus.Done !== 1'b1 || bus.Busy !== 1'b0 || bus.Data_Out !== exp) begin
      errors++;
      $display("FAIL count_zero: done=%b busy=%b data=%h required 1/0/%h",
               bus.Done, bus.Busy, bus.Data_Out, exp);
    end
    step();
    checks++;
    if (bus.Done !== 1'b0) begin
      errors++;
      $display("FAIL count_zero_once: done=%b required 0", bus.Done);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp;
    bit seen_done;
    exp = 8'hC3;
    do_load(exp);
    do_start(3, 2);
    seen_done = 1'b0;
    for (int i = 0; i < 10 && !seen_done; i++) begin
      if (bus.Done === 1'b1) seen_done = 1'b1;
      else step();
    end
    exp = ref_step(ref_step(exp, 3, 1'b0, model_x), 3, 1'b0, model_x);
    checks++;
    if (!seen_done || bus.Data_Out !== exp) begin
      errors++;
      $display("FAIL b2b_first: done_seen=%0d data=%h required 1/%h", seen_done, bus.Data_Out, exp);
    end
    bus.Shift_In = 1'b1;
    do_start(2, 1);
    checks++;
    if (bus.Busy !== 1'b1 || bus.Done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b done=%b required 1/0", bus.Busy, bus.Done);
    end
    step();
    exp = ref_step(exp, 2, 1'b1, model_x);
    checks++;
    if (bus.Data_Out !== exp || bus.Done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second: data=%h done=%b required %h/1", bus.Data_Out, bus.Done, exp);
    end
    bus.Shift_In = 1'b0;
    step();
  endtask

  task automatic test_random();
    logic [W-1:0] exp;
    logic sin;
    int m, c, n;
    for (int it = 0; it < 30; it++) begin
      exp = W'($urandom);
      do_load(exp);
      m = $urandom_range(0, 3);
      c = $urandom_range(0, W + 1);
      n = (c > W) ? W : c;
      do_start(m, c);
      if (n == 0) begin
        checks++;
        if (bus.Done !== 1'b1 || bus.Busy !== 1'b0 || bus.Data_Out !== exp) begin
          errors++;
          $display("FAIL rand_zero it %0d: done=%b busy=%b data=%h required 1/0/%h",
                   it, bus.Done, bus.Busy, bus.Data_Out, exp);
        end
      end else begin
        for (int k = 0; k < n; k++) begin
          checks++;
          if (bus.Busy !== 1'b1 || bus.Done !== 1'b0 ||
              bus.Shift_Out !== ((m == 2) ? exp[W-1] : exp[0])) begin
            errors++;
            $display("FAIL rand_busy it %0d k %0d: busy=%b done=%b so=%b data=%h mode=%0d",
                     it, k, bus.Busy, bus.Done, bus.Shift_Out, exp, m);
          end
          sin = 1'($urandom);
          bus.Shift_In = sin;
          step();
          exp = ref_step(exp, m, sin, model_x);
          checks++;
          if (bus.Data_Out !== exp) begin
            errors++;
            $display("FAIL rand_data it %0d k %0d: got %h required %h mode=%0d",
                     it, k, bus.Data_Out, exp, m);
          end
        end
        checks++;
        if (bus.Done !== 1'b1 || bus.Busy !== 1'b0) begin
          errors++;
          $display("FAIL rand_done it %0d: done=%b busy=%b required 1/0", it, bus.Done, bus.Busy);
        end
      end
      bus.Shift_In = 1'b0;
      step();
    end
  endtask

  task automatic test_xbit();
    logic [7:0] exp_d [2];
`ifdef SHIFT_REG_N_XBIT_EN
    exp_d[0] = 8'h88;
    exp_d[1] = 8'hC4;
    bus.X_Load = 1'b1;
    bus.X_In   = 1'b1;
    do_load(8'h10);
    bus.X_Load = 1'b0;
    bus.X_In   = 1'b0;
    model_x    = 1'b1;
`else
    exp_d[0] = 8'h08;
    exp_d[1] = 8'h04;
    do_load(8'h10);
`endif
    do_start(1, 2);
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (bus.Data_Out !== exp_d[i]) begin
        errors++;
        $display("FAIL xbit_sra step %0d: got %h required %h", i, bus.Data_Out, exp_d[i]);
      end
    end
`ifdef SHIFT_REG_N_XBIT_EN
    checks++;
    if (bus.X !== 1'b1) begin
      errors++;
      $display("FAIL xbit_hold: X=%b required 1", bus.X);
    end
`endif
    step();
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    model_x = 1'b0;
    rst_n   = 1'b0;
    bus.Load     = 1'b0;
    bus.D        = '0;
    bus.Start    = 1'b0;
    bus.Mode     = 2'd0;
    bus.Count    = '0;
    bus.Shift_In = 1'b0;
`ifdef SHIFT_REG_N_XBIT_EN
    bus.X_In   = 1'b0;
    bus.X_Load = 1'b0;
`endif
    step();
    step();
    test_reset();
    test_load();
    test_sra();
    test_sll();
    test_ror_clamp();
    test_collisions();
    test_back_to_back();
    test_xbit();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/shift_reg_n.md
Name: shift_reg_n

Overview:
- Parametrised multi-mode shift register. It is the successor to the fixed 8-bit load/shift register used by the shift-add multiplier datapath.
- Adds selectable shift/rotate modes and a counted multi-step shift command with a start/busy/done handshake.
- Sits in the arithmetic datapath: the controller issues one command and waits for Done instead of pulsing a shift enable per cycle.

Parameters:
- WIDTH, 8, register width in bits (>= 2).
- CNT_W, $clog2(WIDTH+1), width of the shift count.

Ports:
- Clk  in  1  clock, rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- Load  in  1  parallel load request.
- D  in  WIDTH  parallel load data.
- Start  in  1  begin counted shift command.
- Mode  in  2  00 SRL, 01 SRA, 10 SLL, 11 ROR (rotate right).
- Count  in  CNT_W  number of single-bit steps requested.
- Shift_In  in  1  serial input for SRL/SLL, sampled each step.
- Busy  out  1  high while a command is executing.
- Done  out  1  one-cycle completion pulse.
- Shift_Out  out  1  serial output bit.
- Data_Out  out  WIDTH  register contents.

Behaviour:
- Reset_n low (async): Data_Out=0, Busy=0, Done=0, latched mode=SRL, remaining count=0, state IDLE. Release is synchronous to Clk.
- FSM states: IDLE, SHIFT.
- IDLE, Load=1: Data_Out<=D next edge. Load has priority over a simultaneous Start, and that Start is dropped.
- IDLE, Start=1, Load=0: latch Mode and min(Count,WIDTH) into the remaining counter.
  - Count=0: stay IDLE, Done=1 next cycle, data unchanged.
  - Otherwise: go to SHIFT, Busy=1 from the next cycle.
- SHIFT: one step per clock, remaining decrements each step. Step definitions:
  - SRL: {Shift_In, D[W-1:1]}.
  - SRA: {D[W-1], D[W-1:1]}.
  - SLL: {D[W-2:0], Shift_In}.
  - ROR: {D[0], D[W-1:1]}.
- Last step (remaining==1): return to IDLE. Done=1 for exactly the first IDLE cycle, Busy=0 in that cycle.
- Busy is high for exactly N cycles, where N is the clamped count. Done follows the last shifted value by 0 cycles (same cycle).
- Load and Start are ignored while Busy. Mode and Count are only sampled at accepted Start.
- Start asserted in the Done cycle is accepted (back-to-back commands).
- Shift_Out = Data_Out[0] for latched SRL/SRA/ROR; Data_Out[WIDTH-1] for SLL. Combinational from state.
- Reset_n asserted mid-command aborts immediately to the reset values. No Done is produced.

Optional Feature:
- Macro SHIFT_REG_N_XBIT_EN.
- Defined: adds ports X_In (in 1), X_Load (in 1), X (out 1).
  - X is an extension flip-flop, reset 0, loaded from X_In when X_Load=1 in IDLE (same priority rules as Load).
  - SRA steps shift X in at the MSB instead of replicating D[W-1]. X itself is unchanged by shifting.
- Undefined: no X ports or flop; SRA replicates the MSB.

Decomposition:
- Package shift_reg_pkg holds:
  - typedef enum logic [1:0] shift_mode_e {SM_SRL, SM_SRA, SM_SLL, SM_ROR}.
  - typedef enum logic {ST_IDLE, ST_SHIFT} shift_state_e.
- One sub-module, shift_step_counter: loadable down-counter (CNT_W bits, async active-low reset) with a last_step flag. The FSM and data path stay in shift_reg_n.

Test Plan:
- Reset/load: Reset_n=0 mid-run -> Data_Out=0, Busy=0 at once. Then WIDTH=8, Load D=8'hB4 -> Data_Out=8'hB4 next cycle, Done=0.
- SRA by 3: load 8'h94, Start Mode=01 Count=3 -> Busy high 3 cycles, Data_Out 8'hCA, 8'hE5, 8'hF2, Done pulses once in the cycle Data_Out=8'hF2.
- SLL by 2 with serial input: load 8'h81, Shift_In=1, Mode=10 Count=2 -> 8'h03 then 8'h07, Shift_Out follows bit 7 (1, 0, 0).
- ROR with clamp: load 8'h01, Mode=11, Count=9 (WIDTH=8) -> exactly 8 steps, final Data_Out=8'h01, Busy 8 cycles.
- Collisions: Load and Start same cycle -> load only, no Busy. Load and Start during Busy -> ignored. Count=0 -> Done next cycle with data unchanged. Start in Done cycle -> new command accepted.
- XBIT (macro on): X_Load X_In=1, load 8'h10, SRA Count=2 -> 8'h88 then 8'hC4, X stays 1. Macro off -> same stimulus (no X) gives 8'h08, 8'h04.
